// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard for a multi-lane in-order issue group.
// Tracks in-flight writers per stage and lane. Returns forward selects
// of the form {hit, stage, lane} per operand, and an in-order issue mask
// that covers load-use hazards and same-group RAW dependences.
module fwd_scoreboard #(
    parameter int LANES    = 2,
    parameter int STAGES   = 3,
    parameter int LOAD_LAT = 1,
    parameter int AWIDTH   = 5,
    localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1,
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int FW = 1 + SW + LW
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [LANES-1:0]         i_valid,
    input  logic [LANES*AWIDTH-1:0]  i_rs1,
    input  logic [LANES*AWIDTH-1:0]  i_rs2,
    input  logic [LANES*AWIDTH-1:0]  i_rd,
    input  logic [LANES-1:0]         i_regwrite,
    input  logic [LANES-1:0]         i_memread,
    input  logic                     i_flush,
    output logic [LANES-1:0]         o_issue,
    output logic [LANES*FW-1:0]      o_fwd_rs1,
    output logic [LANES*FW-1:0]      o_fwd_rs2,
    output logic                     o_stall,
    output logic [15:0]              o_stall_cnt
);

    logic [STAGES-1:0][LANES-1:0]             ent_v;
    logic [STAGES-1:0][LANES-1:0]             ent_ld;
    logic [STAGES-1:0][LANES-1:0][AWIDTH-1:0] ent_rd;

    logic [LANES-1:0] issue;
    logic [LANES-1:0] hazard;
    logic [LANES-1:0] intra;

    // Youngest-first scoreboard search, same-group RAW detection and prefix issue.
    always_comb begin
        logic              hit1, hit2, prev;
        logic [AWIDTH-1:0] rs1_j, rs2_j, rd_i;
        issue     = '0;
        hazard    = '0;
        intra     = '0;
        o_fwd_rs1 = '0;
        o_fwd_rs2 = '0;
        prev      = 1'b1;
        hit1      = 1'b0;
        hit2      = 1'b0;
        rs1_j     = '0;
        rs2_j     = '0;
        rd_i      = '0;
        for (int j = 0; j < LANES; j++) begin
            rs1_j = i_rs1[j*AWIDTH +: AWIDTH];
            rs2_j = i_rs2[j*AWIDTH +: AWIDTH];
            hit1  = 1'b0;
            hit2  = 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                for (int l = LANES-1; l >= 0; l--) begin
                    if (!hit1 && rs1_j != '0 && ent_v[s][l] && ent_rd[s][l] == rs1_j) begin
                        hit1 = 1'b1;
                        o_fwd_rs1[j*FW +: FW] = {1'b1, SW'(s), LW'(l)};
                        if (ent_ld[s][l] && s < LOAD_LAT)
                            hazard[j] = 1'b1;
                    end
                    if (!hit2 && rs2_j != '0 && ent_v[s][l] && ent_rd[s][l] == rs2_j) begin
                        hit2 = 1'b1;
                        o_fwd_rs2[j*FW +: FW] = {1'b1, SW'(s), LW'(l)};
                        if (ent_ld[s][l] && s < LOAD_LAT)
                            hazard[j] = 1'b1;
                    end
                end
            end
            for (int i = 0; i < j; i++) begin
                rd_i = i_rd[i*AWIDTH +: AWIDTH];
                if (i_valid[i] && i_regwrite[i] && rd_i != '0 &&
                    (rd_i == rs1_j || rd_i == rs2_j))
                    intra[j] = 1'b1;
            end
            issue[j] = i_valid[j] && !hazard[j] && !intra[j] && prev;
            prev     = issue[j];
        end
    end

    assign o_issue = issue;
    assign o_stall = i_valid[0] && !issue[0];

    // Scoreboard shift: older stages always advance, stage 0 records the issued group.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ent_v  <= '0;
            ent_ld <= '0;
            ent_rd <= '0;
        end else begin
            for (int s = 1; s < STAGES; s++) begin
                // A flushed stage-0 group dies instead of moving into stage 1.
                ent_v[s]  <= (i_flush && s == 1) ? '0 : ent_v[s-1];
                ent_ld[s] <= ent_ld[s-1];
                ent_rd[s] <= ent_rd[s-1];
            end
            for (int l = 0; l < LANES; l++) begin
                ent_v[0][l]  <= !i_flush && issue[l] && i_regwrite[l] &&
                                (i_rd[l*AWIDTH +: AWIDTH] != '0);
                ent_ld[0][l] <= i_memread[l];
                ent_rd[0][l] <= i_rd[l*AWIDTH +: AWIDTH];
            end
        end
    end

    // Saturating stall-cycle counter; flushed cycles are not counted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_stall_cnt <= '0;
        else if (o_stall && !i_flush && o_stall_cnt != 16'hFFFF)
            o_stall_cnt <= o_stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: a 2-lane/3-stage instance for the
// forwarding and issue cases, and a 1-lane/16-stage instance with
// LOAD_LAT=15 so that the stall counter can reach saturation.
module tb_fwd_scoreboard;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [1:0]  valid, regwrite, memread, issue;
    logic [9:0]  rs1, rs2, rd;
    logic        flush, stall;
    logic [7:0]  fwd_rs1, fwd_rs2;
    logic [15:0] cnt;

    logic        v2, rw2, mr2, issue2, stall2;
    logic [4:0]  rs1_2, rs2_2, rd2;
    logic [5:0]  fwd2a, fwd2b;
    logic [15:0] cnt2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    fwd_scoreboard #(.LANES(2), .STAGES(3), .LOAD_LAT(1), .AWIDTH(5)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(valid), .i_rs1(rs1),
        .i_rs2(rs2), .i_rd(rd), .i_regwrite(regwrite), .i_memread(memread),
        .i_flush(flush), .o_issue(issue), .o_fwd_rs1(fwd_rs1),
        .o_fwd_rs2(fwd_rs2), .o_stall(stall), .o_stall_cnt(cnt)
    );

    fwd_scoreboard #(.LANES(1), .STAGES(16), .LOAD_LAT(15), .AWIDTH(5)) dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(v2), .i_rs1(rs1_2),
        .i_rs2(rs2_2), .i_rd(rd2), .i_regwrite(rw2), .i_memread(mr2),
        .i_flush(1'b0), .o_issue(issue2), .o_fwd_rs1(fwd2a),
        .o_fwd_rs2(fwd2b), .o_stall(stall2), .o_stall_cnt(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        valid = '0; regwrite = '0; memread = '0; flush = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0;
    endtask

    task automatic set_lane(input int k, input logic v, input logic [4:0] a,
                            input logic [4:0] b, input logic [4:0] d,
                            input logic w, input logic m);
        valid[k] = v; rs1[k*5 +: 5] = a; rs2[k*5 +: 5] = b; rd[k*5 +: 5] = d;
        regwrite[k] = w; memread[k] = m;
    endtask

    task automatic step();
        @(negedge i_clk);
        idle();
    endtask

    initial begin
        i_rst_n = 1'b0;
        idle();
        v2 = 1'b0; rw2 = 1'b0; mr2 = 1'b0; rs1_2 = '0; rs2_2 = '0; rd2 = '0;
        #1;
        chk("rst_fwd_rs1", fwd_rs1, 0);
        chk("rst_stall", stall, 0);
        chk("rst_cnt", cnt, 0);
        set_lane(0, 1, 0, 0, 0, 0, 0);
        set_lane(1, 1, 0, 0, 0, 0, 0);
        #1 chk("rst_issue_comb", issue, 2'b11);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        idle();

        // ALU writer r3 walks EX -> MEM -> WB -> gone
        step(); set_lane(0, 1, 1, 2, 3, 1, 0);
        #1 chk("alu_issue", issue, 2'b01);
        step(); set_lane(0, 1, 3, 0, 0, 0, 0); set_lane(1, 1, 0, 0, 0, 0, 0);
        #1 chk("alu_fwd_s0", fwd_rs1[3:0], 4'b1000);
        chk("alu_issue_n1", issue, 2'b11);
        @(negedge i_clk); #1 chk("alu_fwd_s1", fwd_rs1[3:0], 4'b1010);
        @(negedge i_clk); #1 chk("alu_fwd_s2", fwd_rs1[3:0], 4'b1100);
        @(negedge i_clk); #1 chk("alu_fwd_gone", fwd_rs1[3:0], 4'b0000);

        // load-use: lane1 lw r5, lane0 uses r5 next cycle
        step(); set_lane(0, 1, 0, 0, 0, 0, 0); set_lane(1, 1, 0, 0, 5, 1, 1);
        #1 chk("ld_issue", issue, 2'b11);
        step(); set_lane(0, 1, 0, 5, 0, 0, 0); set_lane(1, 1, 0, 0, 0, 0, 0);
        #1 chk("ld_hz_issue", issue, 2'b00);
        chk("ld_hz_stall", stall, 1);
        chk("ld_hz_cnt", cnt, 0);
        chk("ld_hz_fwd", fwd_rs2[3:0], 4'b1001);
        @(negedge i_clk); #1 chk("ld_ok_cnt", cnt, 1);
        chk("ld_ok_fwd", fwd_rs2[3:0], 4'b1011);
        chk("ld_ok_issue", issue, 2'b11);
        chk("ld_ok_stall", stall, 0);

        // same-group RAW on r7
        step(); set_lane(0, 1, 0, 0, 7, 1, 0); set_lane(1, 1, 7, 0, 0, 0, 0);
        #1 chk("raw_issue", issue, 2'b01);
        step(); set_lane(0, 1, 7, 0, 0, 0, 0);
        #1 chk("raw_fwd", fwd_rs1[3:0], 4'b1000);
        chk("raw_issue_n1", issue, 2'b01);

        // r4 writers at [0][0], [0][1], [1][1]: youngest lane of stage 0 wins
        step(); set_lane(0, 1, 0, 0, 0, 0, 0); set_lane(1, 1, 0, 0, 4, 1, 0);
        #1 chk("r4_issue_a", issue, 2'b11);
        step(); set_lane(0, 1, 0, 0, 4, 1, 0); set_lane(1, 1, 0, 0, 4, 1, 0);
        #1 chk("r4_issue_b", issue, 2'b11);
        step(); set_lane(0, 1, 4, 0, 0, 0, 0); set_lane(1, 1, 0, 0, 0, 1, 0);
        #1 chk("r4_fwd", fwd_rs1[3:0], 4'b1001);
        chk("r4_issue_c", issue, 2'b11);
        step(); set_lane(0, 1, 0, 0, 0, 1, 0); set_lane(1, 1, 0, 0, 0, 0, 0);
        #1 chk("r0_fwd", fwd_rs1[7:4], 4'b0000);
        chk("r0_issue", issue, 2'b11);
        chk("r0_stall", stall, 0);

        // flush: kills stage 0 entries and the issuing group
        step(); step(); step();
        step(); set_lane(0, 1, 0, 0, 10, 1, 0);
        step(); flush = 1'b1;
        step(); set_lane(0, 1, 10, 0, 0, 0, 0);
        #1 chk("flush_s0_fwd", fwd_rs1[3:0], 4'b0000);
        step(); set_lane(0, 1, 0, 0, 9, 1, 0); flush = 1'b1;
        #1 chk("flush_issue", issue, 2'b01);
        step(); set_lane(0, 1, 9, 0, 0, 0, 0);
        #1 chk("flush_grp_fwd", fwd_rs1[3:0], 4'b0000);
        step(); set_lane(0, 1, 0, 0, 12, 1, 1);
        step(); set_lane(0, 1, 12, 0, 0, 0, 0); flush = 1'b1;
        #1 chk("flush_stall", stall, 1);
        step();
        #1 chk("flush_cnt_hold", cnt, 1);

        // asynchronous reset mid-cycle
        step(); set_lane(0, 1, 0, 0, 11, 1, 0);
        step(); set_lane(0, 1, 11, 0, 0, 0, 0);
        #1 chk("pre_rst_fwd", fwd_rs1[3:0], 4'b1000);
        chk("pre_rst_cnt", cnt, 1);
        #2 i_rst_n = 1'b0;
        #1 chk("async_rst_fwd", fwd_rs1[3:0], 4'b0000);
        chk("async_rst_cnt", cnt, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        idle();

        // lw r5,(r5) on 1-lane/16-stage/LOAD_LAT=15: issue then 15 stalls, repeat
        @(negedge i_clk);
        v2 = 1'b1; rs1_2 = 5; rd2 = 5; rw2 = 1'b1; mr2 = 1'b1;
        #1 chk("l1_issue_first", issue2, 1);
        @(negedge i_clk); #1 chk("l1_stall", stall2, 1);
        chk("l1_fwd_s0", fwd2a, 6'b100000);
        chk("l1_fwd_rs2", fwd2b, 0);
        repeat (15) @(negedge i_clk);
        #1 chk("l1_cnt_15", cnt2, 15);
        chk("l1_issue_lat", issue2, 1);
        repeat (70000) @(negedge i_clk);
        #1 chk("l1_cnt_sat", cnt2, 16'hFFFF);
        repeat (50) @(negedge i_clk);
        #1 chk("l1_cnt_sat_hold", cnt2, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the dual-lane forwarding unit of the superscalar MIPS core.
- Replaces per-stage rd/regwrite/memread taps with an internal scoreboard pipeline. The pipeline tracks every in-flight writer across LANES issue lanes and STAGES forwarding tap points.
- Each cycle the block returns, per lane and per operand, a forward select of the form {hit, stage, lane}.
- Loads become forwardable only once they reach stage LOAD_LAT.
- Computes a per-lane issue mask covering load-use stalls and intra-group RAW splits, and keeps a saturating stall-cycle counter.

Parameters:
- LANES, 2, issue width; lane 0 is oldest in program order.
- STAGES, 3, tracked tap points after issue (0=EX, 1=MEM, 2=WB).
- LOAD_LAT, 1, first stage index from which a load result is forwardable; legal range 0..STAGES-1.
- AWIDTH, 5, register address width.
- Derived: SW=max(1,clog2(STAGES)), LW=max(1,clog2(LANES)), FW=1+SW+LW.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_valid  in  LANES  lane holds an instruction requesting issue.
- i_rs1  in  LANES*AWIDTH  source 1 address, lane k at bits [k*AWIDTH +: AWIDTH].
- i_rs2  in  LANES*AWIDTH  source 2 address, same packing.
- i_rd  in  LANES*AWIDTH  destination address, same packing.
- i_regwrite  in  LANES  lane writes rd.
- i_memread  in  LANES  lane is a load.
- i_flush  in  1  kill the issuing group and the stage-0 entries.
- o_issue  out  LANES  lanes allowed to enter EX this cycle.
- o_fwd_rs1  out  LANES*FW  per lane {hit, stage[SW], lane[LW]}, hit at the MSB.
- o_fwd_rs2  out  LANES*FW  same format for rs2.
- o_stall  out  1  i_valid[0] && !o_issue[0].
- o_stall_cnt  out  16  saturating count of stall cycles.

Behaviour:
- State: entry[s][l] = {v, rd, ld} for s<STAGES, l<LANES.
  - Entries are created only when regwrite=1 and rd!=0; otherwise v=0.
- Reset (async, i_rst_n=0): all entry v=0 and o_stall_cnt=0. Outputs become:
  - o_fwd_*=0 and o_stall=0.
  - o_issue = combinational function of the inputs alone.
  - Reset asserted mid-operation drops all tracking immediately.
- Outputs o_issue, o_fwd_*, o_stall are combinational from the entries plus the current-cycle inputs. There is no output register.
- Match for operand x of lane j: entry v=1 and rd==x.
  - x==0 never matches; its fwd is 0 and it never stalls.
- Search order, youngest first: stage 0 to STAGES-1; within a stage, lane LANES-1 down to 0. The first match wins.
  - Winner is an ALU entry, or a load with s>=LOAD_LAT: fwd={1,s,l}, no hazard.
  - Winner is a load with s<LOAD_LAT: hazard. fwd is still reported as {1,s,l} but is not to be used. Older entries are not searched.
  - No match: fwd=0.
- Intra-group RAW: lane j depends on lane i<j when i_valid[i], i_regwrite[i], i_rd[i]!=0, and i_rd[i] equals lane j's rs1 or rs2.
  - Lane j is blocked on intra-group RAW regardless of scoreboard hits.
- Issue rule: o_issue[j] = i_valid[j] && !hazard[j] && !intra[j] && (j==0 || o_issue[j-1]). Issue is in-order and prefix-only; a blocked lane blocks all younger lanes.
- Clock edge, no flush:
  - entry[s] <= entry[s-1] for s>=1. Stages behind EX always advance; a stall inserts a bubble.
  - entry[0][l] <= {o_issue[l] && i_regwrite[l] && rd!=0, i_rd[l], i_memread[l]}.
- Clock edge, i_flush=1:
  - entry[1] is cleared to v=0. The stage-0 group is killed rather than advanced.
  - entry[0] is cleared to v=0; the issuing group is not recorded.
  - Stages >=2 shift from their predecessor as normal.
  - Flush takes precedence over issue.
- Counter: o_stall_cnt increments when o_stall=1 and i_flush=0. It saturates at 16'hFFFF and never wraps.
- LOAD_LAT=0 means loads never cause a hazard.
- LANES=1 means the intra-group logic is absent.

Test Plan (LANES=2, STAGES=3, LOAD_LAT=1, AWIDTH=5):
- Lane0 add r3 issued in cycle N; in N+1 lane0 rs1=3 -> o_fwd_rs1[lane0]={1,2'd0,1'b0}, o_issue=2'b11. In N+2 the fwd is {1,2'd1,0}, and in N+3 it is {1,2'd2,0}; in N+4 it is 0.
- Lane1 lw r5 in N; in N+1 lane0 rs2=5 -> o_issue=2'b00, o_stall=1, o_stall_cnt 0->1. In N+2, with the same inputs, fwd_rs2={1,2'd1,1'b1}, o_issue=2'b11, stall=0.
- Same-group lane0 rd=7 regwrite, lane1 rs1=7 -> o_issue=2'b01. The next cycle re-presents that instruction in lane0 and gets fwd_rs1={1,0,0}.
- Writers of r4 exist at entry[0][0], entry[0][1] and entry[1][1]; query rs1=4 -> fwd={1,2'd0,1'b1}. Query rs1=0 with a writer to r0 attempted -> fwd=0, no stall.
- Issue lane0 writer r9 together with i_flush=1; next cycle query r9 -> fwd=0. Assert i_rst_n=0 mid-stream -> fwd=0 and o_stall_cnt=0 immediately, without waiting for a clock edge.
- Hold a load-use hazard for 70000 cycles -> o_stall_cnt=16'hFFFF and stays there.
